// File: rtl/periph_bus_bridge.sv
// Memory-stage to 16-bit peripheral bus bridge: runs 1 or 3 beats per request, then pulses HANDSHAKE.
// Optional macro PBB_TIMEOUT_EN adds a per-beat ACK timeout (READ all ones, ERROR set).
module periph_bus_bridge #(
  parameter int BEAT_W  = 16,
  parameter int PADDR_W = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ENABLE,
  input  logic [2:0]         CTRL,
  input  logic [47:0]        ADDRESS,
  input  logic [47:0]        WDATA,
  output logic [47:0]        READ,
  output logic               HANDSHAKE,
  output logic               ERROR,
  output logic               BUS_REQ,
  output logic               BUS_WE,
  output logic [PADDR_W-1:0] BUS_ADDR,
  output logic [BEAT_W-1:0]  BUS_WDATA,
  input  logic [BEAT_W-1:0]  BUS_RDATA,
  input  logic               BUS_ACK
);

  typedef enum logic [1:0] {IDLE, XFER, DONE, HOLD} BridgeState;

  BridgeState         state;
  BridgeState         stateNext;
  logic               accept;
  logic               reject;
  logic               beatDone;
  logic               timeoutHit;
  logic               opWrite;
  logic [1:0]         idx;
  logic [1:0]         lastIdx;
  logic [PADDR_W-1:0] baseQ;
  logic [47:0]        wdataQ;
  logic [47:0]        readQ;
  logic               errQ;
  logic               unusedAddrBits;

  assign unusedAddrBits = ^ADDRESS[47:PADDR_W];

`ifdef PBB_TIMEOUT_EN
  logic [7:0] waitCnt;
`else
  logic [7:0] unusedTimeout;
  assign unusedTimeout = 8'(TIMEOUT);
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= stateNext;
  end

  // The request is only sampled in IDLE; HOLD blocks a still-held ENABLE from re-running it.
  always_comb begin
    stateNext  = state;
    accept     = 1'b0;
    reject     = 1'b0;
    beatDone   = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      IDLE: begin
        if (ENABLE) begin
          if (CTRL[2]) begin
            reject    = 1'b1;
            stateNext = DONE;
          end else begin
            accept    = 1'b1;
            stateNext = XFER;
          end
        end
      end
      XFER: begin
        if (BUS_ACK) begin
          beatDone = 1'b1;
          if (idx == lastIdx) stateNext = DONE;
        end
`ifdef PBB_TIMEOUT_EN
        else if (waitCnt == 8'(TIMEOUT - 1)) begin
          timeoutHit = 1'b1;
          stateNext  = DONE;
        end
`endif
      end
      DONE:    stateNext = HOLD;
      HOLD:    if (!ENABLE) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      opWrite <= 1'b0;
      idx     <= 2'd0;
      lastIdx <= 2'd0;
      baseQ   <= '0;
      wdataQ  <= '0;
      readQ   <= '0;
      errQ    <= 1'b0;
    end else begin
      if (accept) begin
        opWrite <= CTRL[1];
        lastIdx <= CTRL[0] ? 2'd0 : 2'd2;
        baseQ   <= ADDRESS[PADDR_W-1:0];
        wdataQ  <= WDATA;
        idx     <= 2'd0;
        readQ   <= '0;
        errQ    <= 1'b0;
      end
      if (reject) begin
        readQ <= '0;
        errQ  <= 1'b1;
      end
      // Little-endian assembly: beat 0 lands in the low slice, rd16 stays zero-extended.
      if (beatDone) begin
        idx <= idx + 2'd1;
        if (!opWrite) begin
          case (idx)
            2'd0:    readQ[BEAT_W-1:0]          <= BUS_RDATA;
            2'd1:    readQ[2*BEAT_W-1:BEAT_W]   <= BUS_RDATA;
            default: readQ[3*BEAT_W-1:2*BEAT_W] <= BUS_RDATA;
          endcase
        end
      end
      if (timeoutHit) begin
        readQ <= '1;
        errQ  <= 1'b1;
      end
    end
  end

`ifdef PBB_TIMEOUT_EN
  // Counts stalled cycles of the current beat; any ACK or leaving XFER restarts it.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)                                      waitCnt <= 8'd0;
    else if (state == XFER && !BUS_ACK && !timeoutHit) waitCnt <= waitCnt + 8'd1;
    else                                             waitCnt <= 8'd0;
  end
`endif

  always_comb begin
    BUS_WDATA = '0;
    if (state == XFER) begin
      case (idx)
        2'd0:    BUS_WDATA = wdataQ[BEAT_W-1:0];
        2'd1:    BUS_WDATA = wdataQ[2*BEAT_W-1:BEAT_W];
        default: BUS_WDATA = wdataQ[3*BEAT_W-1:2*BEAT_W];
      endcase
    end
  end

  assign BUS_REQ   = (state == XFER);
  assign BUS_WE    = (state == XFER) && opWrite;
  assign BUS_ADDR  = (state == XFER) ? baseQ + PADDR_W'(idx) : '0;
  assign HANDSHAKE = (state == DONE);
  assign READ      = readQ;
  assign ERROR     = errQ;

endmodule

// File: tb/tb_periph_bus_bridge.sv
// Scoreboard bench for periph_bus_bridge: random requests, a queued bus responder and a decoupled monitor.
// Define PBB_TIMEOUT_EN for both bench and RTL to exercise the ACK timeout.
module tb_periph_bus_bridge;

  localparam int TIMEOUT = 255;

  typedef struct { logic [15:0] addr; logic we; logic [15:0] wdata; } BeatExp;
  typedef struct { logic [47:0] read; logic err; int cyc; } DoneExp;
  typedef struct { int waitCycles; logic [15:0] rdata; } BeatPlan;

  logic        CLK;
  logic        RESET;
  logic        ENABLE;
  logic [2:0]  CTRL;
  logic [47:0] ADDRESS;
  logic [47:0] WDATA;
  logic [47:0] READ;
  logic        HANDSHAKE;
  logic        ERROR;
  logic        BUS_REQ;
  logic        BUS_WE;
  logic [15:0] BUS_ADDR;
  logic [15:0] BUS_WDATA;
  logic [15:0] BUS_RDATA;
  logic        BUS_ACK;

  BeatExp  expBeatQ[$];
  DoneExp  expDoneQ[$];
  BeatPlan planQ[$];

  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int hsCount = 0;
  int beatCount = 0;
  bit idlePulse = 1'b0;

  periph_bus_bridge #(.BEAT_W(16), .PADDR_W(16), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .CTRL(CTRL), .ADDRESS(ADDRESS),
    .WDATA(WDATA), .READ(READ), .HANDSHAKE(HANDSHAKE), .ERROR(ERROR),
    .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR), .BUS_WDATA(BUS_WDATA),
    .BUS_RDATA(BUS_RDATA), .BUS_ACK(BUS_ACK)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial forever begin
    @(posedge CLK);
    cycle++;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Bus slave: serves planned beats in order, each after its planned number of wait cycles.
  initial begin
    BeatPlan cur;
    bit haveBeat;
    int waitLeft;
    haveBeat  = 1'b0;
    waitLeft  = 0;
    BUS_ACK   = 1'b0;
    BUS_RDATA = 16'h0;
    forever begin
      @(negedge CLK);
      BUS_ACK = 1'b0;
      if (!BUS_REQ) begin
        haveBeat = 1'b0;
        if (idlePulse) begin
          BUS_ACK   = 1'b1;
          BUS_RDATA = 16'($urandom);
        end
      end else begin
        if (!haveBeat && planQ.size() > 0) begin
          cur      = planQ.pop_front();
          haveBeat = 1'b1;
          waitLeft = cur.waitCycles;
        end
        if (haveBeat) begin
          if (waitLeft == 0) begin
            BUS_ACK   = 1'b1;
            BUS_RDATA = cur.rdata;
            haveBeat  = 1'b0;
          end else begin
            waitLeft--;
          end
        end
      end
    end
  end

  // Monitor: compares every request cycle and every HANDSHAKE against the scoreboard queues.
  initial begin
    BeatExp e;
    DoneExp d;
    forever begin
      @(negedge CLK);
      #2;
      if (RESET) begin
        if (BUS_REQ) begin
          if (expBeatQ.size() == 0) begin
            checkOutput("spurious BUS_REQ", 64'd1, 64'd0);
          end else begin
            e = expBeatQ[0];
            checkOutput("BUS_ADDR", 64'(BUS_ADDR), 64'(e.addr));
            checkOutput("BUS_WE", 64'(BUS_WE), 64'(e.we));
            checkOutput("BUS_WDATA", 64'(BUS_WDATA), 64'(e.wdata));
            if (BUS_ACK) begin
              void'(expBeatQ.pop_front());
              beatCount++;
            end
          end
        end
        if (HANDSHAKE) begin
          hsCount++;
          if (expDoneQ.size() == 0) begin
            checkOutput("spurious HANDSHAKE", 64'd1, 64'd0);
          end else begin
            d = expDoneQ.pop_front();
            checkOutput("READ", 64'(READ), 64'(d.read));
            checkOutput("ERROR", 64'(ERROR), 64'(d.err));
            checkOutput("HANDSHAKE cycle", 64'(cycle), 64'(d.cyc));
          end
        end
      end
    end
  end

  // Builds the expected beats and completion from the operation rules, then runs one request.
  task automatic applyStimulus(input logic [2:0] ctrl, input logic [47:0] addr, input logic [47:0] wdata,
                               input logic [47:0] rdata, input int w0, input int w1, input int w2,
                               input int holdExtra, input bit dropEarly);
    int nBeats;
    int lat;
    int waits[3];
    int start;
    logic [15:0] rd;
    logic [47:0] expRead;
    waits   = '{w0, w1, w2};
    nBeats  = ctrl[2] ? 0 : (ctrl[0] ? 1 : 3);
    lat     = 1;
    expRead = 48'h0;
    @(negedge CLK);
    for (int i = 0; i < nBeats; i++) begin
      rd = 16'(rdata >> (16 * i));
      planQ.push_back('{waits[i], rd});
      expBeatQ.push_back('{16'((int'(addr[15:0]) + i) % 65536), ctrl[1], 16'(wdata >> (16 * i))});
      lat += waits[i] + 1;
      if (!ctrl[1]) expRead |= 48'(rd) << (16 * i);
    end
    expDoneQ.push_back('{expRead, ctrl[2], cycle + lat});
    start   = hsCount;
    ENABLE  = 1'b1;
    CTRL    = ctrl;
    ADDRESS = addr;
    WDATA   = wdata;
    if (dropEarly) begin
      @(negedge CLK);
      ENABLE  = 1'b0;
      CTRL    = 3'($urandom);
      ADDRESS = {16'($urandom), $urandom};
      WDATA   = {16'($urandom), $urandom};
    end
    for (int t = 0; t < 200 && hsCount == start; t++) @(negedge CLK);
    checkOutput("handshake count", 64'(hsCount), 64'(start + 1));
    repeat (holdExtra) @(negedge CLK);
    ENABLE = 1'b0;
    @(negedge CLK);
    checkOutput("READ held after done", 64'(READ), 64'(expRead));
    checkOutput("ERROR held after done", 64'(ERROR), 64'(ctrl[2]));
    checkOutput("handshake once", 64'(hsCount), 64'(start + 1));
    checkOutput("leftover beats", 64'(expBeatQ.size()), 64'd0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " READ"}, 64'(READ), 64'd0);
    checkOutput({tag, " HANDSHAKE"}, 64'(HANDSHAKE), 64'd0);
    checkOutput({tag, " ERROR"}, 64'(ERROR), 64'd0);
    checkOutput({tag, " BUS_REQ"}, 64'(BUS_REQ), 64'd0);
    checkOutput({tag, " BUS_WE"}, 64'(BUS_WE), 64'd0);
    checkOutput({tag, " BUS_ADDR"}, 64'(BUS_ADDR), 64'd0);
    checkOutput({tag, " BUS_WDATA"}, 64'(BUS_WDATA), 64'd0);
  endtask

  initial begin
    int base;
    int start;
    logic [2:0] c;
    RESET   = 1'b0;
    ENABLE  = 1'b0;
    CTRL    = 3'd0;
    ADDRESS = 48'h0;
    WDATA   = 48'h0;
    repeat (3) @(negedge CLK);
    checkResetOutputs("reset");
    RESET = 1'b1;

    idlePulse = 1'b1;
    repeat (5) @(negedge CLK);
    idlePulse = 1'b0;
    @(negedge CLK);
    checkOutput("idle BUS_REQ", 64'(BUS_REQ), 64'd0);
    checkOutput("idle handshakes", 64'(hsCount), 64'd0);

    applyStimulus(3'b000, 48'h10, 48'h0, 48'h3333_2222_1111, 0, 0, 0, 0, 1'b0);
    applyStimulus(3'b011, 48'hFFFF, 48'h0000_0000_ABCD, 48'h0, 3, 0, 0, 10, 1'b0);
    applyStimulus(3'b010, 48'hFFFE, 48'h1234_5678_9ABC, 48'h0, 1, 0, 2, 0, 1'b0);
    applyStimulus(3'b101, 48'h40, 48'h0, 48'h0, 0, 0, 0, 2, 1'b0);
    applyStimulus(3'b001, 48'hABCD_0000_0020, 48'h0, 48'h0000_0000_5A5A, 0, 0, 0, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      c = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      applyStimulus(c, {16'($urandom), $urandom}, {16'($urandom), $urandom}, {16'($urandom), $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Reset during the third beat of an rd48: bus request must drop without waiting for a clock.
    @(negedge CLK);
    base = beatCount;
    start = hsCount;
    for (int i = 0; i < 3; i++) begin
      planQ.push_back('{(i == 2) ? 20 : 0, 16'($urandom)});
      expBeatQ.push_back('{16'(16'h0200 + i), 1'b0, 16'h0});
    end
    ENABLE  = 1'b1;
    CTRL    = 3'b000;
    ADDRESS = 48'h200;
    WDATA   = 48'h0;
    for (int t = 0; t < 50 && beatCount < base + 2; t++) @(negedge CLK);
    checkOutput("beats before reset", 64'(beatCount), 64'(base + 2));
    @(negedge CLK);
    #3;
    RESET = 1'b0;
    #1;
    checkOutput("async BUS_REQ drop", 64'(BUS_REQ), 64'd0);
    ENABLE = 1'b0;
    @(negedge CLK);
    expBeatQ.delete();
    planQ.delete();
    checkResetOutputs("mid-reset");
    RESET = 1'b1;
    repeat (5) @(negedge CLK);
    checkOutput("no handshake after reset", 64'(hsCount), 64'(start));
    applyStimulus(3'b010, 48'h7, 48'hCAFE_BEEF_F00D, 48'h0, 0, 1, 0, 1, 1'b0);

`ifdef PBB_TIMEOUT_EN
    @(negedge CLK);
    start = hsCount;
    planQ.push_back('{1000000, 16'h0});
    expBeatQ.push_back('{16'h0300, 1'b0, 16'h0});
    expDoneQ.push_back('{48'hFFFF_FFFF_FFFF, 1'b1, cycle + 1 + TIMEOUT});
    ENABLE  = 1'b1;
    CTRL    = 3'b000;
    ADDRESS = 48'h300;
    WDATA   = 48'h0;
    for (int t = 0; t < 400 && hsCount == start; t++) @(negedge CLK);
    checkOutput("timeout handshake", 64'(hsCount), 64'(start + 1));
    ENABLE = 1'b0;
    @(negedge CLK);
    expBeatQ.delete();
    planQ.delete();
    checkOutput("timeout READ held", 64'(READ), 64'hFFFF_FFFF_FFFF);
    checkOutput("timeout ERROR held", 64'(ERROR), 64'd1);
    applyStimulus(3'b001, 48'h9, 48'h0, 48'h0000_0000_1357, 0, 0, 0, 0, 1'b0);
`endif

    repeat (3) @(negedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/periph_bus_bridge.md
Name: periph_bus_bridge

Overview:
Multi-cycle peripheral bridge that sits directly downstream of the CPU memory stage, next to the clock-gating unit. It takes the memory-stage request (enable, control code, address and store data) and runs one to three 16-bit beats on the narrow peripheral bus. It assembles or splits 48-bit words and pulses HANDSHAKE so the gated CPU clock resumes. It is a write-capable companion to the existing read-only peripheral path and serves the same wait/handshake protocol.

Parameters:
BEAT_W, 16, peripheral bus data width; 48/BEAT_W must be 3.
PADDR_W, 16, peripheral address width; taken from ADDRESS[PADDR_W-1:0].
TIMEOUT, 255, maximum cycles waiting for BUS_ACK per beat; the counter is 8 bits wide.

Ports:
CLK  in  1  clock; same clock that drives the memory-access logic (ungated master clock).
RESET  in  1  asynchronous reset, active-low.
ENABLE  in  1  request valid from memory stage; held high while the CPU clock is gated.
CTRL  in  3  operation code: 000 rd48, 001 rd16, 010 wr48, 011 wr16; 1xx illegal.
ADDRESS  in  48  byte address from the memory-stage ALU output.
WDATA  in  48  store data from the memory stage.
READ  out  48  assembled read data, valid from the HANDSHAKE cycle until the next accept.
HANDSHAKE  out  1  one-cycle completion pulse to the clock gate.
ERROR  out  1  sticky error flag; cleared at the next accepted request.
BUS_REQ  out  1  beat request.
BUS_WE  out  1  write beat.
BUS_ADDR  out  PADDR_W  beat address.
BUS_WDATA  out  BEAT_W  beat write data.
BUS_RDATA  in  BEAT_W  beat read data, sampled when BUS_REQ and BUS_ACK are both high.
BUS_ACK  in  1  beat acknowledge.

Behaviour:
- Reset (RESET=0, asynchronous) clears all outputs to 0, puts the FSM in IDLE, and clears the beat index, timeout counter and ERROR.
- FSM states: IDLE, XFER, DONE, HOLD.
- IDLE, ENABLE=1, CTRL legal:
  - latch CTRL, ADDRESS[PADDR_W-1:0] and WDATA;
  - set beats = 3 for 48-bit ops, 1 for 16-bit ops;
  - clear ERROR and READ; go to XFER.
- IDLE, ENABLE=1, CTRL illegal: set ERROR=1, force READ=0, go to DONE (no bus activity).
- XFER:
  - BUS_REQ=1; BUS_WE=1 for write ops.
  - BUS_ADDR = latched base + beat index, modulo 2^PADDR_W (wraps at 16'hFFFF).
  - BUS_WDATA = WDATA[16*i +: 16].
  - On BUS_ACK=1: for reads, READ[16*i +: 16] <= BUS_RDATA. Increment the index. After the last beat, go to DONE with BUS_REQ dropped the next cycle.
  - rd16 zero-extends the result to 48 bits. Little-endian: beat 0 maps to bits [15:0].
- DONE: HANDSHAKE=1 for exactly one cycle, then go to HOLD.
- HOLD: wait for ENABLE=0, then go to IDLE. This guarantees a held request is never re-executed.
- Latency, ACK same cycle as REQ:
  - rd48/wr48: accept at cycle 0, beats at cycles 1–3, HANDSHAKE at cycle 4.
  - rd16/wr16: HANDSHAKE at cycle 2.
- BUS_ACK outside XFER is ignored. ENABLE dropping mid-XFER does not abort the transfer; it completes.
- Reset asserted mid-transfer aborts immediately. BUS_REQ falls asynchronously; no HANDSHAKE is issued.

Optional Feature:
Macro PBB_TIMEOUT_EN.
- Defined: an 8-bit counter runs while BUS_REQ=1 and BUS_ACK=0, and resets on each ACK. When it reaches TIMEOUT:
  - abort the remaining beats;
  - set READ=48'hFFFF_FFFF_FFFF and ERROR=1;
  - go to DONE, so HANDSHAKE still pulses.
- Undefined: no counter; XFER waits for BUS_ACK indefinitely and ERROR is set only by illegal CTRL.

Test Plan:
1. Reset held low, then released -> all outputs 0, FSM in IDLE; BUS_ACK pulses produce no activity.
2. rd48 at ADDRESS=0x10, ACK immediate, BUS_RDATA 0x1111/0x2222/0x3333 -> BUS_ADDR 0x10,0x11,0x12; READ=48'h3333_2222_1111; HANDSHAKE one cycle at cycle 4.
3. wr16 at ADDRESS=0xFFFF, WDATA=48'h0000_0000_ABCD, ACK after 3 wait cycles -> BUS_WE=1, BUS_WDATA=0xABCD held 4 cycles; HANDSHAKE once. ENABLE held high 10 more cycles -> no second transaction.
4. wr48 at 0xFFFE -> BUS_ADDR sequence 0xFFFE, 0xFFFF, 0x0000.
5. CTRL=3'b101 -> no BUS_REQ; ERROR=1, READ=0, HANDSHAKE at cycle 1. The next legal request clears ERROR.
6. With PBB_TIMEOUT_EN defined, rd48 with ACK never asserted -> HANDSHAKE after 255 wait cycles, READ all ones, ERROR=1. Also: RESET pulled low during beat 2 -> BUS_REQ drops asynchronously, no HANDSHAKE.
